// File: rtl/fir_pkg.sv
// Shared FIR definitions: tap count/width, coefficient-controller FSM state,
// and the default coefficient set loaded into bank 0 when FIR_COEFF_DEFAULT_EN
// is defined.
package fir_pkg;

  localparam int order = 53;
  localparam int width = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } fir_coeff_state_t;

  // Symmetric low-pass prototype, tap 0 first.
  localparam logic signed [width-1:0] FIRfilterCoeffs [order] = '{
    -16'sd12,   -16'sd20,   -16'sd25,   -16'sd21,   16'sd0,     16'sd37,
    16'sd78,    16'sd100,   16'sd77,    16'sd0,     -16'sd119,  -16'sd240,
    -16'sd300,  -16'sd230,  16'sd0,     16'sd365,   16'sd760,   16'sd996,
    16'sd780,   16'sd0,     -16'sd1080, -16'sd2275, -16'sd3055, -16'sd2532,
    16'sd0,     16'sd6410,  16'sd9830,  16'sd6410,  16'sd0,     -16'sd2532,
    -16'sd3055, -16'sd2275, -16'sd1080, 16'sd0,     16'sd780,   16'sd996,
    16'sd760,   16'sd365,   16'sd0,     -16'sd230,  -16'sd300,  -16'sd240,
    -16'sd119,  16'sd0,     16'sd77,    16'sd100,   16'sd78,    16'sd37,
    16'sd0,     -16'sd21,   -16'sd25,   -16'sd20,   -16'sd12
  };

  // Default tap j, or zero when a build uses more taps than the table holds.
  function automatic logic [width-1:0] default_coeff(input int j);
    if (j >= 0 && j < order) return FIRfilterCoeffs[j];
    return '0;
  endfunction

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient load stream between host/config logic and fir_coeff_ctrl.
interface fir_coeff_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             load_start;
  logic             coef_valid;
  logic [WIDTH-1:0] coef_data;
  logic             coef_ready;

  modport master (
    output load_start,
    output coef_valid,
    output coef_data,
    input  coef_ready
  );

  modport slave (
    input  load_start,
    input  coef_valid,
    input  coef_data,
    output coef_ready
  );

endinterface

// File: rtl/fir_coeff_bank.sv
// ORDER x WIDTH coefficient register bank: one write port, flattened read.
// RESET_DEFAULT selects reset to fir_pkg::FIRfilterCoeffs instead of zero.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int ORDER         = order,
  parameter int WIDTH         = width,
  parameter bit RESET_DEFAULT = 1'b0,
  localparam int AW           = (ORDER > 1) ? $clog2(ORDER) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [ORDER*WIDTH-1:0] rdata_flat
);

  for (genvar j = 0; j < ORDER; j++) begin : g_tap
    localparam logic [WIDTH-1:0] RST_VAL =
      RESET_DEFAULT ? WIDTH'(default_coeff(j)) : '0;

    logic [WIDTH-1:0] tap_q;

    // Tap register: reset value, then written only when addressed.
    // NOTE: these are discrete flops feeding the adder tree, not a RAM, so a
    // synchronous reset of every tap is cheap and legal here.
    always_ff @(posedge clk) begin
      if (reset) begin
        tap_q <= RST_VAL;
      end else if (we && addr == AW'(j)) begin
        tap_q <= wdata;
      end
    end

    assign rdata_flat[j*WIDTH +: WIDTH] = tap_q;
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient controller. A new set streams into the
// shadow bank while the active bank feeds the filter; banks swap on the next
// sample strobe once the set is complete.
// Optional macro FIR_COEFF_DEFAULT_EN: bank 0 resets to FIRfilterCoeffs.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int ORDER = order,
  parameter int WIDTH = width,
  localparam int AW   = (ORDER > 1) ? $clog2(ORDER) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_coeff_ctrl_if.slave        coef_if,
  input  logic                   sample_valid,
  output logic [ORDER*WIDTH-1:0] coef_bank_flat,
  output logic                   active_bank,
  output logic                   busy,
  output logic                   swap_done,
  output logic                   load_error
);

`ifdef FIR_COEFF_DEFAULT_EN
  localparam bit BANK0_DEFAULT = 1'b1;
`else
  localparam bit BANK0_DEFAULT = 1'b0;
`endif

  fir_coeff_state_t state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             active_q, active_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;
  logic             we;
  logic             hs;
  logic [ORDER*WIDTH-1:0] rd0, rd1;

  // Outputs decode registered state only; no input-to-output paths.
  assign coef_if.coef_ready = (state_q == LOAD);
  assign busy               = (state_q != IDLE);
  assign active_bank        = active_q;
  assign swap_done          = swap_q;
  assign load_error         = err_q;
  assign hs                 = coef_if.coef_valid & coef_if.coef_ready;

  // State and control registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      active_q <= 1'b0;
      swap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      swap_q   <= swap_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: load_start always wins over a handshake or a swap.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    swap_d   = 1'b0;
    err_d    = err_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (coef_if.load_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (coef_if.load_start) begin
          idx_d = '0;
          err_d = 1'b1;
        end else if (hs) begin
          we = 1'b1;
          if (idx_q == AW'(ORDER - 1)) begin
            state_d = ARMED;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ARMED: begin
        if (coef_if.load_start) begin
          state_d = LOAD;
          idx_d   = '0;
          err_d   = 1'b1;
        end else if (sample_valid) begin
          state_d  = IDLE;
          active_d = ~active_q;
          swap_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fir_coeff_bank #(
    .ORDER(ORDER), .WIDTH(WIDTH), .RESET_DEFAULT(BANK0_DEFAULT)
  ) u_bank0 (
    .clk(clk), .reset(reset), .we(we & active_q), .addr(idx_q),
    .wdata(coef_if.coef_data), .rdata_flat(rd0)
  );

  fir_coeff_bank #(
    .ORDER(ORDER), .WIDTH(WIDTH), .RESET_DEFAULT(1'b0)
  ) u_bank1 (
    .clk(clk), .reset(reset), .we(we & ~active_q), .addr(idx_q),
    .wdata(coef_if.coef_data), .rdata_flat(rd1)
  );

  assign coef_bank_flat = active_q ? rd1 : rd0;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl at ORDER=4, WIDTH=8. A transaction
// model (word queue count, loading/armed flags, two packed banks) predicts
// every output after each clock edge.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;

  localparam int ORDER = 4;
  localparam int WIDTH = 8;
  localparam int FW    = ORDER * WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_valid = 1'b0;
  logic [FW-1:0] coef_bank_flat;
  logic          active_bank, busy, swap_done, load_error;

  fir_coeff_ctrl_if #(.WIDTH(WIDTH)) coef_if ();

  fir_coeff_ctrl #(.ORDER(ORDER), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .coef_if(coef_if), .sample_valid(sample_valid),
    .coef_bank_flat(coef_bank_flat), .active_bank(active_bank), .busy(busy),
    .swap_done(swap_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [FW-1:0] m_banks [2];
  logic          m_active, m_loading, m_armed, m_err, m_swap;
  int            m_count;

  wire [FW+4:0] act_vec = {coef_bank_flat, active_bank, busy,
                           coef_if.coef_ready, swap_done, load_error};

  function automatic logic [FW-1:0] default_flat();
    logic [FW-1:0] f;
    f = '0;
`ifdef FIR_COEFF_DEFAULT_EN
    for (int j = 0; j < ORDER; j++) f[j*WIDTH +: WIDTH] = FIRfilterCoeffs[j][WIDTH-1:0];
`endif
    return f;
  endfunction

  function automatic logic [FW+4:0] exp_vec();
    return {m_banks[m_active], m_active, m_loading | m_armed, m_loading, m_swap, m_err};
  endfunction

  task automatic model_step(input logic rst, ls, cv, input logic [WIDTH-1:0] cd,
                            input logic sv);
    m_swap = 1'b0;
    if (rst) begin
      m_banks[0] = default_flat();
      m_banks[1] = '0;
      m_active = 1'b0; m_loading = 1'b0; m_armed = 1'b0; m_err = 1'b0;
      m_count = 0;
    end else if (m_loading) begin
      if (ls) begin
        m_count = 0;
        m_err = 1'b1;
      end else if (cv) begin
        m_banks[!m_active][m_count*WIDTH +: WIDTH] = cd;
        m_count++;
        if (m_count == ORDER) begin
          m_loading = 1'b0;
          m_armed = 1'b1;
        end
      end
    end else if (m_armed) begin
      if (ls) begin
        m_armed = 1'b0; m_loading = 1'b1; m_count = 0; m_err = 1'b1;
      end else if (sv) begin
        m_active = !m_active; m_armed = 1'b0; m_swap = 1'b1;
      end
    end else if (ls) begin
      m_loading = 1'b1;
      m_count = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and settle past the edge.
  task automatic cycle(input logic rst, ls, cv, input logic [WIDTH-1:0] cd,
                       input logic sv);
    reset = rst;
    coef_if.load_start = ls;
    coef_if.coef_valid = cv;
    coef_if.coef_data = cd;
    sample_valid = sv;
    model_step(rst, ls, cv, cd, sv);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 1, 1, 8'h5A, 1);
    cycle(0, 0, 0, 8'h00, 0);
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_model act=%h exp=%h", act_vec, exp_vec());
    end
    n_vec++;
    if (coef_bank_flat !== default_flat() || active_bank !== 1'b0 || busy !== 1'b0 ||
        coef_if.coef_ready !== 1'b0 || swap_done !== 1'b0 || load_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values act=%h exp=%h", act_vec, {default_flat(), 5'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w [ORDER];
    w = '{8'h01, 8'h02, 8'h03, 8'h04};
    cycle(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < ORDER; i++) begin
      cycle(0, 0, 1, w[i], 0);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_load[%0d] act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 1);
    n_vec++;
    if (coef_bank_flat !== 32'h04030201 || active_bank !== 1'b1 || swap_done !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_swap act=%h exp_flat=04030201 bank=1 swap=1", act_vec);
    end
    cycle(0, 0, 0, 8'h00, 0);
    n_vec++;
    if (swap_done !== 1'b0 || busy !== 1'b0 || coef_bank_flat !== 32'h04030201) begin
      n_err++;
      $display("FAIL b2b_after act=%h exp swap=0 busy=0", act_vec);
    end
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] w [ORDER];
    logic [5:0]       pat;
    logic [FW-1:0]    old_flat, new_flat;
    int               k;
    pat = 6'b101101;
    for (int i = 0; i < ORDER; i++) w[i] = WIDTH'($urandom);
    new_flat = {w[3], w[2], w[1], w[0]};
    old_flat = m_banks[m_active];
    cycle(0, 1, 0, 8'h00, 0);
    k = 0;
    for (int i = 5; i >= 0; i--) begin
      if (pat[i]) begin
        cycle(0, 0, 1, w[k], 0);
        k++;
      end else begin
        cycle(0, 0, 0, WIDTH'($urandom), 0);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 8'h00, 0);
      n_vec++;
      if (coef_bank_flat !== old_flat || busy !== 1'b1 || coef_if.coef_ready !== 1'b0) begin
        n_err++;
        $display("FAIL gaps_armed[%0d] act=%h exp_flat=%h busy=1 ready=0", i, act_vec, old_flat);
      end
    end
    cycle(0, 0, 0, 8'h00, 1);
    n_vec++;
    if (coef_bank_flat !== new_flat || act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL gaps_swap act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_sv_on_last();
    logic bank0;
    bank0 = m_active;
    cycle(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < ORDER; i++) cycle(0, 0, 1, WIDTH'($urandom), (i == ORDER - 1));
    n_vec++;
    if (active_bank !== bank0 || busy !== 1'b1 || swap_done !== 1'b0) begin
      n_err++;
      $display("FAIL sv_on_last act_bank=%b exp=%b busy=%b swap=%b", active_bank, bank0, busy, swap_done);
    end
    cycle(0, 0, 0, 8'h00, 1);
    n_vec++;
    if (active_bank !== !bank0 || act_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL sv_after_last act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_abort_armed();
    logic bank0;
    bank0 = m_active;
    cycle(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < ORDER; i++) cycle(0, 0, 1, WIDTH'($urandom), 0);
    cycle(0, 1, 0, 8'h00, 1);
    n_vec++;
    if (active_bank !== bank0 || load_error !== 1'b1 || coef_if.coef_ready !== 1'b1 ||
        swap_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_armed act=%h exp=%h", act_vec, exp_vec());
    end
    for (int i = 0; i < ORDER; i++) cycle(0, 0, 1, WIDTH'(8'h0A + i), 0);
    cycle(0, 0, 0, 8'h00, 1);
    n_vec++;
    if (coef_bank_flat !== 32'h0D0C0B0A || active_bank !== !bank0 || load_error !== 1'b1) begin
      n_err++;
      $display("FAIL abort_reload act=%h exp_flat=0d0c0b0a", act_vec);
    end
  endtask

  task automatic test_reset_midload();
    logic [WIDTH-1:0] w [ORDER];
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'hAA, 0);
    cycle(0, 0, 1, 8'hBB, 0);
    cycle(1, 0, 0, 8'h00, 0);
    n_vec++;
    if (act_vec !== {default_flat(), 5'b0}) begin
      n_err++;
      $display("FAIL reset_midload act=%h exp=%h", act_vec, {default_flat(), 5'b0});
    end
    for (int i = 0; i < ORDER; i++) w[i] = WIDTH'($urandom);
    cycle(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < ORDER; i++) cycle(0, 0, 1, w[i], 0);
    cycle(0, 0, 0, 8'h00, 1);
    n_vec++;
    if (active_bank !== 1'b1 || coef_bank_flat !== {w[3], w[2], w[1], w[0]}) begin
      n_err++;
      $display("FAIL reset_reload act=%h exp_flat=%h bank=1", act_vec, {w[3], w[2], w[1], w[0]});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 3) == 0);
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d] act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    coef_if.load_start = 1'b0;
    coef_if.coef_valid = 1'b0;
    coef_if.coef_data  = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_sv_on_last();
    test_abort_armed();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient bank controller for the parallel FIR adder-tree datapath. It accepts a new coefficient set over a valid/ready stream into a shadow bank while the filter keeps running on the active bank. It then swaps banks atomically on a sample boundary, so no output sample ever mixes old and new taps. It sits between the host/config logic and the FIR filter's coefficient inputs.

## Interface
- `ORDER`, default 53: number of taps, matching the codebase `order`.
- `WIDTH`, default 16: coefficient width, matching the codebase `width`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_start` in 1: pulse that begins, or restarts, a load session.
- `coef_valid` in 1: coefficient word valid.
- `coef_data` in WIDTH: coefficient word, sent tap 0 first.
- `coef_ready` out 1: controller accepts a word this cycle.
- `sample_valid` in 1: a new sample enters the filter's delay line this cycle.
- `coef_bank_flat` out ORDER*WIDTH: active coefficients; tap j is at bits [j*WIDTH +: WIDTH].
- `active_bank` out 1: index of the bank currently driving `coef_bank_flat`.
- `busy` out 1: high in LOAD or ARMED.
- `swap_done` out 1: one-cycle pulse after a bank swap.
- `load_error` out 1: sticky; set when a session is aborted.

## Operation
- Storage: two banks of ORDER x WIDTH registers. The active bank drives `coef_bank_flat`; the other is the shadow bank.
- FSM states: IDLE, LOAD, ARMED.
- IDLE: on `load_start`, go to LOAD and set the write index to 0.
- LOAD:
  - `coef_ready` = 1.
  - Each handshake (`coef_valid & coef_ready`) writes `coef_data` to shadow[idx] and increments idx.
  - The handshake at idx == ORDER-1 moves the FSM to ARMED.
  - `load_start` in LOAD: idx returns to 0, the FSM stays in LOAD, and `load_error` is set. Any handshake in the same cycle is discarded.
- ARMED:
  - `coef_ready` = 0.
  - On `sample_valid`: `active_bank` toggles, the FSM returns to IDLE, and `swap_done` pulses in the following cycle.
  - `load_start` in ARMED: the FSM returns to LOAD with idx 0 and `load_error` is set. `load_start` beats `sample_valid` in the same cycle, so no swap occurs.
- `load_start` in IDLE never sets `load_error`. Only `reset` clears `load_error`.
- The active bank is never written. Shadow writes never affect `coef_bank_flat`.
- `sample_valid` outside ARMED is ignored.
- Arithmetic: idx is $clog2(ORDER) bits wide and never wraps past ORDER-1. Coefficients are stored and passed through unmodified.

## Timing
- Reset values:
  - state IDLE, idx 0, `active_bank` 0.
  - `coef_ready` 0, `busy` 0, `swap_done` 0, `load_error` 0.
  - Both banks zero, except as described under Configuration.
- `coef_ready` and `busy` are decoded from the registered state only. There is no combinational path from `coef_valid` or `load_start` to any output.
- Minimum load time is ORDER cycles; gaps in `coef_valid` extend it one cycle per gap.
- The handshake on the last word moves the FSM to ARMED at that edge. A `sample_valid` in the same cycle as the last word does not swap.
- Swap latency:
  - `sample_valid` in ARMED at cycle N: `coef_bank_flat` and `active_bank` change at edge N+1.
  - `swap_done` is high during cycle N+1 only.
  - The sample strobed at N uses the old taps; the next sample uses the new taps.
- ARMED may persist indefinitely; the old coefficients stay valid throughout.
- `reset` mid-load or while ARMED: everything returns to reset values and the partial set is lost.

## Configuration
- Macro: `FIR_COEFF_DEFAULT_EN`.
- Defined: on reset, bank 0 is loaded with the package constant `FIRfilterCoeffs`, so the filter works with no load session. Bank 1 resets to zero.
- Not defined: both banks reset to zero and the filter outputs 0 until the first swap.

## Structure
- Shared package `fir_pkg`:
  - FSM state enum `fir_coeff_state_t`.
  - `FIRfilterCoeffs` default coefficient array.
  - Shared `order`/`width` constants.
- Sub-module `fir_coeff_bank`: ORDER x WIDTH register bank with a single write port (`we`, `addr`, `wdata`), synchronous reset to zero or to the defaults, and a flattened read output. Instantiated twice.
- A mux driven by `active_bank` selects the read output.

## Test plan
All scenarios use ORDER=4, WIDTH=8.
- Reset: `active_bank`=0, `coef_bank_flat`=0x00000000, all other outputs 0. With `FIR_COEFF_DEFAULT_EN`, `coef_bank_flat` equals the packed `FIRfilterCoeffs`.
- Back-to-back load of 0x01, 0x02, 0x03, 0x04, then `sample_valid` two cycles later:
  - `coef_bank_flat`=0x04030201 and `active_bank`=1 at the next edge.
  - `swap_done` high exactly 1 cycle; `busy` low afterwards.
- Load with `coef_valid` gaps (pattern 1,0,1,1,0,1), then no `sample_valid` for 10 cycles: output stays on the old bank, `busy`=1, `coef_ready`=0. The first `sample_valid` swaps.
- `sample_valid` in the same cycle as the 4th handshake: no swap. The next `sample_valid` swaps.
- In ARMED, `load_start` and `sample_valid` in the same cycle:
  - No swap and `load_error`=1.
  - A reload of 0x0A..0x0D then swaps to 0x0D0C0B0A.
- `reset` after 2 of 4 words: all outputs return to reset values. A following full load and swap selects bank 1 correctly.
